// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: data width, operation codes
// (matching RISC-V funct3[1:0]) and FSM state encoding.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the pipeline (master) and the divider (slave).
interface div_unit_if;
  import div_unit_pkg::*;

  logic                 start;
  logic [1:0]           op;
  logic [DIV_WIDTH-1:0] a;
  logic [DIV_WIDTH-1:0] b;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);

endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient
// bit per cycle on operand magnitudes with sign fix-up at the end.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on the start edge
// S_CALC | 32 iterations of shift/subtract/restore
// S_DONE | result valid, done pulses for this one cycle
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state, state_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] quot, divisor, result_q;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  logic             op_signed, div_zero, overflow, want_rem;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] rem_sh, diff;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quot_step, q_final, r_final;

  always_comb begin
    op_signed = (op_e'(bus.op) == OP_DIV) || (op_e'(bus.op) == OP_REM);
    div_zero  = (bus.b == '0);
    overflow  = op_signed && (bus.a == MIN_NEG) && (bus.b == '1);
    a_mag     = (op_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    b_mag     = (op_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  end

  // One iteration; the extra top bit makes the subtraction sign unambiguous.
  always_comb begin
    rem_sh = {rem, quot[WIDTH-1]};
    diff   = rem_sh - {2'b00, divisor};
    if (!diff[WIDTH+1]) begin
      rem_step  = diff[WIDTH:0];
      quot_step = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = rem_sh[WIDTH:0];
      quot_step = {quot[WIDTH-2:0], 1'b0};
    end
    q_final  = neg_q ? (~quot_step + 1'b1) : quot_step;
    r_final  = neg_r ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
    want_rem = (op_q == OP_REM) || (op_q == OP_REMU);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = (div_zero || overflow) ? S_DONE : S_CALC;
      S_CALC:  if (cnt == '1) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_DIV;
      quot     <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q <= op_e'(bus.op);
            if (div_zero) begin
              result_q <= bus.op[1] ? bus.a : '1;
            end else if (overflow) begin
              result_q <= bus.op[1] ? '0 : MIN_NEG;
            end else begin
              quot    <= a_mag;
              divisor <= b_mag;
              rem     <= '0;
              cnt     <= '0;
              neg_q   <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_r   <= op_signed && bus.a[WIDTH-1];
            end
          end
        end
        S_CALC: begin
          quot <= quot_step;
          rem  <= rem_step;
          cnt  <= cnt + 1'b1;
          if (cnt == '1) result_q <= want_rem ? r_final : q_final;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: per-scenario tasks with hand-computed
// results and latencies, inputs driven and outputs sampled on the falling edge.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  div_unit_if bus ();

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation and waits (bounded) for done; ends one cycle after
  // done so the FSM is back in IDLE for the next request.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    r = bus.result;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    vectors++;
    if (bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h expected 00000000", bus.result);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [31:0] r;
    int lat;
    run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
    vectors++;
    if (r !== 32'd14) begin
      miscompares++;
      $display("FAIL divu_100_7: got %h expected %h", r, 32'd14);
    end
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL divu_latency: got %0d expected 33", lat);
    end
    // result must hold while idle even if the operand buses wander
    bus.a = 32'h1234_5678;
    bus.b = 32'h3;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.result !== 32'd14) begin
      miscompares++;
      $display("FAIL result_hold: got %h expected %h", bus.result, 32'd14);
    end
    run_op(OP_REMU, 32'd100, 32'd7, r, lat);
    vectors++;
    if (r !== 32'd2) begin
      miscompares++;
      $display("FAIL remu_100_7: got %h expected %h", r, 32'd2);
    end
  endtask

  task automatic test_signed();
    logic [31:0] r;
    int lat;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, lat);
    vectors++;
    if (r !== 32'hFFFF_FFFD) begin
      miscompares++;
      $display("FAIL div_m7_2: got %h expected FFFFFFFD", r);
    end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat);
    vectors++;
    if (r !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL rem_m7_2: got %h expected FFFFFFFF", r);
    end
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, r, lat);
    vectors++;
    if (r !== 32'd1) begin
      miscompares++;
      $display("FAIL rem_7_m2: got %h expected 00000001", r);
    end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, r, lat);
    vectors++;
    if (r !== 32'hFFFF_FFFD) begin
      miscompares++;
      $display("FAIL div_7_m2: got %h expected FFFFFFFD", r);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    int lat;
    run_op(OP_DIVU, 32'd5, 32'd0, r, lat);
    vectors++;
    if (r !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL divu_by0: got %h expected FFFFFFFF", r);
    end
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL divu_by0_latency: got %0d expected 1", lat);
    end
    run_op(OP_REM, 32'd5, 32'd0, r, lat);
    vectors++;
    if (r !== 32'd5) begin
      miscompares++;
      $display("FAIL rem_by0: got %h expected 00000005", r);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int lat;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    vectors++;
    if (r !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL div_ovf: got %h expected 80000000", r);
    end
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL div_ovf_latency: got %0d expected 1", lat);
    end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL rem_ovf: got %h expected 00000000", r);
    end
    // same bit pattern unsigned takes the normal path: 0x80000000 / 0xFFFFFFFF = 0
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    vectors++;
    if (r !== 32'h0 || lat !== 33) begin
      miscompares++;
      $display("FAIL divu_big: got %h lat %0d expected 00000000 lat 33", r, lat);
    end
  endtask

  task automatic test_zero_dividend();
    logic [31:0] r;
    int lat;
    run_op(OP_DIVU, 32'd0, 32'd5, r, lat);
    vectors++;
    if (r !== 32'h0 || lat !== 33) begin
      miscompares++;
      $display("FAIL divu_0_5: got %h lat %0d expected 00000000 lat 33", r, lat);
    end
    run_op(OP_REM, 32'd0, 32'hFFFF_FFFD, r, lat);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL rem_0_m3: got %h expected 00000000", r);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra_done;
    int busy_seen;
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 60) begin
      if (lat == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_REM;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
      end
      if (lat == 6) bus.start = 1'b0;
      if (lat == 20) begin
        bus.a = 32'd10;
        bus.b = 32'd2;
      end
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (bus.result !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL divu_max_1: got %h expected FFFFFFFF", bus.result);
    end
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL divu_max_latency: got %0d expected 33", lat);
    end
    extra_done = 0;
    busy_seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) extra_done++;
      if (bus.busy) busy_seen++;
    end
    vectors++;
    if (extra_done !== 0 || busy_seen !== 0) begin
      miscompares++;
      $display("FAIL no_queued_start: got done=%0d busy=%0d expected 0 0", extra_done, busy_seen);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] r;
    int lat;
    int stray_done;
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd1000;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b done=%b result=%h expected 0 0 00000000",
               bus.busy, bus.done, bus.result);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray_done++;
    end
    vectors++;
    if (stray_done !== 0) begin
      miscompares++;
      $display("FAIL aborted_no_done: got %0d active cycles expected 0", stray_done);
    end
    run_op(OP_DIVU, 32'd9, 32'd3, r, lat);
    vectors++;
    if (r !== 32'd3 || lat !== 33) begin
      miscompares++;
      $display("FAIL post_reset_divu: got %h lat %0d expected 00000003 lat 33", r, lat);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_zero_dividend();
    test_ignore_start();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
